// File: rtl/sample_merge.sv
// -----------------------------------------------------------------------------
// sample_merge
// Assembles a little-endian byte stream from the ADC/IF front end into signed
// WIDTH-bit samples for the downstream FIR. Each completed word is published
// for one cycle in PUBLISH with a single-cycle strobe. A partial word is thrown
// away (and frame_err_o latched) if the stream stalls for TIMEOUT cycles or if
// start_i drops mid-word.
//
// Ports
//   clk              rising-edge clock
//   rst              synchronous, active-high reset (highest priority)
//   start_i          run enable shared with the FIR
//   byte_valid_i     byte_i carries a byte this cycle
//   byte_i[7:0]      incoming byte
//   byte_ready_o     byte_i is accepted this cycle (COLLECT and start_i)
//   data_o           last assembled sample, held between strobes
//   merge_finished_o one-cycle strobe marking a new data_o
//   frame_err_o      sticky: a partial word was discarded
//   sample_cnt_o     wrapping count of published samples
// -----------------------------------------------------------------------------
module sample_merge #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic                    byte_valid_i,
    input  logic [7:0]              byte_i,
    output logic                    byte_ready_o,
    output logic signed [WIDTH-1:0] data_o,
    output logic                    merge_finished_o,
    output logic                    frame_err_o,
    output logic [15:0]             sample_cnt_o
);

    localparam int NBYTES = WIDTH / 8;
    localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int IW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [CW-1:0] LAST_BYTE  = CW'(NBYTES - 1);
    localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_PUBLISH = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     byte_cnt_q, byte_cnt_d;
    logic [IW-1:0]     idle_cnt_q, idle_cnt_d;
    logic [WIDTH-1:0]  word_q, word_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              strobe_q, strobe_d;
    logic              frame_err_q, frame_err_d;
    logic [15:0]       sample_cnt_q, sample_cnt_d;
    logic              byte_ready_s;

    // Ready is combinational on start_i so a falling run enable stops intake at once.
    assign byte_ready_s = (state_q == S_COLLECT) && start_i && !rst;

    // Next-state, byte assembly, idle timeout and publish bookkeeping.
    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        word_d       = word_q;
        data_d       = data_q;
        strobe_d     = 1'b0;
        frame_err_d  = frame_err_q;
        sample_cnt_d = sample_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_COLLECT;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_COLLECT: begin
                if (!start_i) begin
                    // Run enable dropped: abandon the word; only a real partial is an error.
                    state_d    = S_IDLE;
                    byte_cnt_d = {CW{1'b0}};
                    idle_cnt_d = {IW{1'b0}};
                    if (byte_cnt_q != {CW{1'b0}}) begin
                        frame_err_d = 1'b1;
                    end else begin
                        frame_err_d = frame_err_q;
                    end
                end else if (byte_valid_i) begin
                    // Byte k lands in bits [8k+7:8k]; earlier bytes of this word are already in place.
                    word_d[{byte_cnt_q, 3'b000} +: 8] = byte_i;
                    idle_cnt_d = {IW{1'b0}};
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_d   = {CW{1'b0}};
                        data_d       = word_d;
                        strobe_d     = 1'b1;
                        sample_cnt_d = sample_cnt_q + 16'd1;
                        state_d      = S_PUBLISH;
                    end else begin
                        byte_cnt_d = byte_cnt_q + CW'(1);
                    end
                end else if (byte_cnt_q != {CW{1'b0}}) begin
                    // Stalled mid-word: count idle cycles and drop the partial at the limit.
                    if (idle_cnt_q == IDLE_LIMIT) begin
                        byte_cnt_d  = {CW{1'b0}};
                        idle_cnt_d  = {IW{1'b0}};
                        frame_err_d = 1'b1;
                    end else begin
                        idle_cnt_d = idle_cnt_q + IW'(1);
                    end
                end else begin
                    idle_cnt_d = {IW{1'b0}};
                end
            end

            S_PUBLISH: begin
                if (start_i) begin
                    state_d = S_COLLECT;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d    = S_IDLE;
                byte_cnt_d = {CW{1'b0}};
                idle_cnt_d = {IW{1'b0}};
            end
        endcase
    end

    // State and output registers; rst overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            byte_cnt_q   <= {CW{1'b0}};
            idle_cnt_q   <= {IW{1'b0}};
            word_q       <= {WIDTH{1'b0}};
            data_q       <= {WIDTH{1'b0}};
            strobe_q     <= 1'b0;
            frame_err_q  <= 1'b0;
            sample_cnt_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            word_q       <= word_d;
            data_q       <= data_d;
            strobe_q     <= strobe_d;
            frame_err_q  <= frame_err_d;
            sample_cnt_q <= sample_cnt_d;
        end
    end

    assign byte_ready_o     = byte_ready_s;
    assign data_o           = data_q;
    assign merge_finished_o = strobe_q;
    assign frame_err_o      = frame_err_q;
    assign sample_cnt_o     = sample_cnt_q;

endmodule

// File: tb/tb_sample_merge.sv
// -----------------------------------------------------------------------------
// tb_sample_merge
// Directed bench for sample_merge (WIDTH=32, TIMEOUT=1024). Inputs change and
// outputs are observed on the falling clock edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_sample_merge;

    localparam int MIN_INT = -2147483647 - 1;

    logic               clk;
    logic               rst;
    logic               start_i;
    logic               byte_valid_i;
    logic [7:0]         byte_i;
    logic               byte_ready_o;
    logic signed [31:0] data_o;
    logic               merge_finished_o;
    logic               frame_err_o;
    logic [15:0]        sample_cnt_o;

    int vectors    = 0;
    int miscompares = 0;

    // Strobe monitor state
    int          strobe_cnt  = 0;
    int          consec_cnt  = 0;
    logic        prev_strobe = 1'b0;
    logic [31:0] pub_q[$];

    sample_merge #(.WIDTH(32), .TIMEOUT(1024)) dut (
        .clk              (clk),
        .rst              (rst),
        .start_i          (start_i),
        .byte_valid_i     (byte_valid_i),
        .byte_i           (byte_i),
        .byte_ready_o     (byte_ready_o),
        .data_o           (data_o),
        .merge_finished_o (merge_finished_o),
        .frame_err_o      (frame_err_o),
        .sample_cnt_o     (sample_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts strobes, records published words, flags back-to-back strobes.
    always @(negedge clk) begin
        if (merge_finished_o) begin
            strobe_cnt <= strobe_cnt + 1;
            pub_q.push_back(data_o);
            if (prev_strobe) consec_cnt <= consec_cnt + 1;
        end
        prev_strobe <= merge_finished_o;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Presents the four bytes of w (LSB first) on consecutive cycles.
    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            byte_valid_i = 1'b1;
            byte_i       = w[8*k +: 8];
            tick();
        end
        byte_valid_i = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input int n);
        logic [7:0] bs [3];
        bs[0] = b0; bs[1] = b1; bs[2] = b2;
        for (int k = 0; k < n; k++) begin
            byte_valid_i = 1'b1;
            byte_i       = bs[k];
            tick();
        end
        byte_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b1; byte_valid_i = 1'b1; byte_i = 8'hA5;
        repeat (3) tick();
        vectors++; if (data_o !== 32'h0) begin miscompares++; $display("FAIL reset_data got %h exp %h", data_o, 32'h0); end
        vectors++; if (merge_finished_o !== 1'b0) begin miscompares++; $display("FAIL reset_strobe got %b exp 0", merge_finished_o); end
        vectors++; if (byte_ready_o !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b exp 0", byte_ready_o); end
        vectors++; if (frame_err_o !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err got %b exp 0", frame_err_o); end
        vectors++; if (sample_cnt_o !== 16'd0) begin miscompares++; $display("FAIL reset_cnt got %0d exp 0", sample_cnt_o); end
        rst = 1'b0; start_i = 1'b0; byte_valid_i = 1'b0;
        tick();
        vectors++; if (byte_ready_o !== 1'b0) begin miscompares++; $display("FAIL idle_ready got %b exp 0", byte_ready_o); end
    endtask

    task automatic test_basic();
        int s0;
        start_i = 1'b1;
        tick();
        vectors++; if (byte_ready_o !== 1'b1) begin miscompares++; $display("FAIL basic_ready got %b exp 1", byte_ready_o); end
        s0 = strobe_cnt;
        send_word(32'h12345678);
        vectors++; if (merge_finished_o !== 1'b1) begin miscompares++; $display("FAIL basic_strobe got %b exp 1", merge_finished_o); end
        vectors++; if (data_o !== 32'h12345678) begin miscompares++; $display("FAIL basic_data got %h exp %h", data_o, 32'h12345678); end
        vectors++; if (sample_cnt_o !== 16'd1) begin miscompares++; $display("FAIL basic_cnt got %0d exp 1", sample_cnt_o); end
        vectors++; if (byte_ready_o !== 1'b0) begin miscompares++; $display("FAIL basic_pub_ready got %b exp 0", byte_ready_o); end
        tick();
        vectors++; if (merge_finished_o !== 1'b0) begin miscompares++; $display("FAIL basic_strobe_end got %b exp 0", merge_finished_o); end
        vectors++; if (byte_ready_o !== 1'b1) begin miscompares++; $display("FAIL basic_back_ready got %b exp 1", byte_ready_o); end
        vectors++; if (data_o !== 32'h12345678) begin miscompares++; $display("FAIL basic_hold got %h exp %h", data_o, 32'h12345678); end
        vectors++; if (strobe_cnt - s0 !== 1) begin miscompares++; $display("FAIL basic_nstrobe got %0d exp 1", strobe_cnt - s0); end
    endtask

    task automatic test_signed();
        int s0;
        int got_s;
        s0 = strobe_cnt;
        send_word(32'h80000000);
        got_s = data_o;
        vectors++; if (data_o !== 32'h80000000) begin miscompares++; $display("FAIL signed_data got %h exp %h", data_o, 32'h80000000); end
        vectors++; if (got_s !== MIN_INT) begin miscompares++; $display("FAIL signed_value got %0d exp %0d", got_s, MIN_INT); end
        vectors++; if (sample_cnt_o !== 16'd2) begin miscompares++; $display("FAIL signed_cnt got %0d exp 2", sample_cnt_o); end
        tick();
        vectors++; if (strobe_cnt - s0 !== 1) begin miscompares++; $display("FAIL signed_nstrobe got %0d exp 1", strobe_cnt - s0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bq [8];
        int idx, cycles, pub_seen, ready_in_pub, s0, c0;
        logic rdy;
        bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        idx = 0; cycles = 0; pub_seen = 0; ready_in_pub = 0;
        s0 = strobe_cnt; c0 = consec_cnt;
        pub_q.delete();
        byte_valid_i = 1'b1;
        byte_i       = bq[0];
        while (idx < 8 && cycles < 20) begin
            if (merge_finished_o) begin
                pub_seen++;
                if (byte_ready_o) ready_in_pub++;
            end
            rdy = byte_ready_o;
            tick();
            cycles++;
            if (rdy) begin
                idx++;
                if (idx < 8) byte_i = bq[idx];
            end
        end
        byte_valid_i = 1'b0;
        vectors++; if (merge_finished_o !== 1'b1) begin miscompares++; $display("FAIL b2b_last_strobe got %b exp 1", merge_finished_o); end
        vectors++; if (byte_ready_o !== 1'b0) begin miscompares++; $display("FAIL b2b_last_pub_ready got %b exp 0", byte_ready_o); end
        tick(); tick();
        vectors++; if (idx !== 8) begin miscompares++; $display("FAIL b2b_accepted got %0d exp 8", idx); end
        vectors++; if (cycles !== 9) begin miscompares++; $display("FAIL b2b_cycles got %0d exp 9", cycles); end
        vectors++; if (pub_seen !== 1) begin miscompares++; $display("FAIL b2b_mid_publish got %0d exp 1", pub_seen); end
        vectors++; if (ready_in_pub !== 0) begin miscompares++; $display("FAIL b2b_pub_ready got %0d exp 0", ready_in_pub); end
        vectors++; if (strobe_cnt - s0 !== 2) begin miscompares++; $display("FAIL b2b_nstrobe got %0d exp 2", strobe_cnt - s0); end
        vectors++; if (consec_cnt - c0 !== 0) begin miscompares++; $display("FAIL b2b_consecutive got %0d exp 0", consec_cnt - c0); end
        vectors++; if (pub_q.size() !== 2) begin miscompares++; $display("FAIL b2b_npub got %0d exp 2", pub_q.size()); end
        if (pub_q.size() == 2) begin
            vectors++; if (pub_q[0] !== 32'h44332211) begin miscompares++; $display("FAIL b2b_word0 got %h exp %h", pub_q[0], 32'h44332211); end
            vectors++; if (pub_q[1] !== 32'h88776655) begin miscompares++; $display("FAIL b2b_word1 got %h exp %h", pub_q[1], 32'h88776655); end
        end
        vectors++; if (sample_cnt_o !== 16'd4) begin miscompares++; $display("FAIL b2b_cnt got %0d exp 4", sample_cnt_o); end
    endtask

    task automatic test_start_drop();
        int s0;
        s0 = strobe_cnt;
        vectors++; if (frame_err_o !== 1'b0) begin miscompares++; $display("FAIL drop_pre_err got %b exp 0", frame_err_o); end
        send_bytes(8'hA1, 8'hA2, 8'hA3, 3);
        start_i = 1'b0;
        #1;
        vectors++; if (byte_ready_o !== 1'b0) begin miscompares++; $display("FAIL drop_ready got %b exp 0", byte_ready_o); end
        tick();
        vectors++; if (frame_err_o !== 1'b1) begin miscompares++; $display("FAIL drop_err got %b exp 1", frame_err_o); end
        tick();
        start_i = 1'b1;
        tick();
        vectors++; if (byte_ready_o !== 1'b1) begin miscompares++; $display("FAIL drop_rearm_ready got %b exp 1", byte_ready_o); end
        send_word(32'hDDCCBBAA);
        vectors++; if (data_o !== 32'hDDCCBBAA) begin miscompares++; $display("FAIL drop_data got %h exp %h", data_o, 32'hDDCCBBAA); end
        vectors++; if (sample_cnt_o !== 16'd5) begin miscompares++; $display("FAIL drop_cnt got %0d exp 5", sample_cnt_o); end
        tick();
        vectors++; if (strobe_cnt - s0 !== 1) begin miscompares++; $display("FAIL drop_nstrobe got %0d exp 1", strobe_cnt - s0); end
    endtask

    task automatic test_reset_mid_word();
        int s0;
        s0 = strobe_cnt;
        send_bytes(8'h5A, 8'hA5, 8'h00, 2);
        byte_valid_i = 1'b1; byte_i = 8'hFF; rst = 1'b1;
        #1;
        vectors++; if (byte_ready_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_ready_now got %b exp 0", byte_ready_o); end
        tick();
        vectors++; if (data_o !== 32'h0) begin miscompares++; $display("FAIL rstmid_data got %h exp 0", data_o); end
        vectors++; if (merge_finished_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_strobe got %b exp 0", merge_finished_o); end
        vectors++; if (frame_err_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_err got %b exp 0", frame_err_o); end
        vectors++; if (sample_cnt_o !== 16'd0) begin miscompares++; $display("FAIL rstmid_cnt got %0d exp 0", sample_cnt_o); end
        vectors++; if (byte_ready_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_ready got %b exp 0", byte_ready_o); end
        rst = 1'b0; byte_valid_i = 1'b0;
        tick();
        send_word(32'hCAFEF00D);
        vectors++; if (data_o !== 32'hCAFEF00D) begin miscompares++; $display("FAIL rstmid_word got %h exp %h", data_o, 32'hCAFEF00D); end
        vectors++; if (sample_cnt_o !== 16'd1) begin miscompares++; $display("FAIL rstmid_post_cnt got %0d exp 1", sample_cnt_o); end
        tick();
        vectors++; if (strobe_cnt - s0 !== 1) begin miscompares++; $display("FAIL rstmid_nstrobe got %0d exp 1", strobe_cnt - s0); end
    endtask

    task automatic test_timeout();
        int s0;
        s0 = strobe_cnt;
        vectors++; if (frame_err_o !== 1'b0) begin miscompares++; $display("FAIL tmo_pre_err got %b exp 0", frame_err_o); end
        send_bytes(8'hEE, 8'hDD, 8'h00, 2);
        repeat (1023) tick();
        vectors++; if (frame_err_o !== 1'b0) begin miscompares++; $display("FAIL tmo_early_err got %b exp 0", frame_err_o); end
        tick();
        vectors++; if (frame_err_o !== 1'b1) begin miscompares++; $display("FAIL tmo_err got %b exp 1", frame_err_o); end
        vectors++; if (data_o !== 32'hCAFEF00D) begin miscompares++; $display("FAIL tmo_hold got %h exp %h", data_o, 32'hCAFEF00D); end
        send_word(32'h01020304);
        vectors++; if (data_o !== 32'h01020304) begin miscompares++; $display("FAIL tmo_data got %h exp %h", data_o, 32'h01020304); end
        vectors++; if (sample_cnt_o !== 16'd2) begin miscompares++; $display("FAIL tmo_cnt got %0d exp 2", sample_cnt_o); end
        tick();
        vectors++; if (strobe_cnt - s0 !== 1) begin miscompares++; $display("FAIL tmo_nstrobe got %0d exp 1", strobe_cnt - s0); end
        vectors++; if (frame_err_o !== 1'b1) begin miscompares++; $display("FAIL tmo_sticky got %b exp 1", frame_err_o); end
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; byte_valid_i = 1'b0; byte_i = 8'h00;
        test_reset();
        test_basic();
        test_signed();
        test_back_to_back();
        test_start_drop();
        test_reset_mid_word();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
